dmac_wr_arbiter: RTL

- Round-robin arbiter that shares the single AXI write path (AW/W/B) of the DMA controller among N_CH channel engines.
- Grants the AW channel to one engine, then locks the W channel to that engine until its burst's last beat.
- Routes B responses back to the owning engine by ID.
- Sits between the per-channel engines and the AXI master ports of the DMAC top.

---
 rtl/dmac_pkg.sv | 38 +++
 rtl/dmac_wr_arbiter_if.sv | 61 ++++++
 rtl/dmac_rr_arbiter.sv | 17 +
 rtl/dmac_wr_arbiter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/dmac_pkg.sv
// rtl/dmac_pkg.sv - shared types, AXI constants and round-robin helper for the DMAC write arbiter
package dmac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AW   = 2'd1,
        W    = 2'd2
    } dmac_state_t;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // Widest channel count the picker supports; narrower request vectors are zero-extended.
    localparam int MAX_CH = 8;

    // Returns the first set request scanning ptr+1, ptr+2, ... modulo n_ch.
    // If nothing is requesting, the pointer itself is returned.
    function automatic logic [2:0] rr_pick(input logic [MAX_CH-1:0] req,
                                           input logic [2:0]        ptr,
                                           input int unsigned       n_ch);
        logic [2:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 1; i <= MAX_CH; i++) begin
            if (i <= n_ch) begin
                idx = (ptr + i) % n_ch;
                if (!found && req[idx]) begin
                    pick  = idx[2:0];
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/dmac_wr_arbiter_if.sv
// rtl/dmac_wr_arbiter_if.sv - per-channel and AXI write-path bundle for the DMAC write arbiter
interface dmac_wr_arbiter_if #(
    parameter int N_CH   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    // Channel-engine side
    logic [N_CH-1:0]          ch_awvalid_i;
    logic [N_CH-1:0]          ch_awready_o;
    logic [N_CH*ADDR_W-1:0]   ch_awaddr_i;
    logic [N_CH*4-1:0]        ch_awlen_i;
    logic [N_CH-1:0]          ch_wvalid_i;
    logic [N_CH-1:0]          ch_wready_o;
    logic [N_CH*DATA_W-1:0]   ch_wdata_i;
    logic [N_CH*DATA_W/8-1:0] ch_wstrb_i;
    logic [N_CH-1:0]          ch_wlast_i;
    logic [N_CH-1:0]          ch_bvalid_o;
    logic [N_CH-1:0]          ch_bready_i;
    logic [1:0]               ch_bresp_o;

    // AXI master side
    logic [ID_W-1:0]          awid_o;
    logic [ADDR_W-1:0]        awaddr_o;
    logic [3:0]               awlen_o;
    logic [2:0]               awsize_o;
    logic [1:0]               awburst_o;
    logic                     awvalid_o;
    logic                     awready_i;
    logic [ID_W-1:0]          wid_o;
    logic [DATA_W-1:0]        wdata_o;
    logic [DATA_W/8-1:0]      wstrb_o;
    logic                     wlast_o;
    logic                     wvalid_o;
    logic                     wready_i;
    logic [ID_W-1:0]          bid_i;
    logic [1:0]               bresp_i;
    logic                     bvalid_i;
    logic                     bready_o;

    // Arbiter view: it is the AXI master toward the interconnect.
    modport master (
        input  ch_awvalid_i, ch_awaddr_i, ch_awlen_i, ch_wvalid_i, ch_wdata_i,
               ch_wstrb_i, ch_wlast_i, ch_bready_i,
               awready_i, wready_i, bid_i, bresp_i, bvalid_i,
        output ch_awready_o, ch_wready_o, ch_bvalid_o, ch_bresp_o,
               awid_o, awaddr_o, awlen_o, awsize_o, awburst_o, awvalid_o,
               wid_o, wdata_o, wstrb_o, wlast_o, wvalid_o, bready_o
    );

    // Environment view: channel engines plus the AXI slave.
    modport slave (
        output ch_awvalid_i, ch_awaddr_i, ch_awlen_i, ch_wvalid_i, ch_wdata_i,
               ch_wstrb_i, ch_wlast_i, ch_bready_i,
               awready_i, wready_i, bid_i, bresp_i, bvalid_i,
        input  ch_awready_o, ch_wready_o, ch_bvalid_o, ch_bresp_o,
               awid_o, awaddr_o, awlen_o, awsize_o, awburst_o, awvalid_o,
               wid_o, wdata_o, wstrb_o, wlast_o, wvalid_o, bready_o
    );

endinterface

// File: rtl/dmac_rr_arbiter.sv
// rtl/dmac_rr_arbiter.sv - combinational round-robin picker (request vector + pointer -> grant index)
module dmac_rr_arbiter
    import dmac_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int GNT_W = 2
) (
    input  logic [N_CH-1:0]  i_req,
    input  logic [GNT_W-1:0] i_ptr,
    output logic [GNT_W-1:0] o_gnt,
    output logic             o_valid
);

    assign o_gnt   = GNT_W'(rr_pick(MAX_CH'(i_req), 3'(i_ptr), N_CH));
    assign o_valid = |i_req;

endmodule

// File: rtl/dmac_wr_arbiter.sv
// rtl/dmac_wr_arbiter.sv - round-robin AW/W/B arbiter for the DMAC write path (option: DMAC_WR_ARB_GNT_CNT_EN)
module dmac_wr_arbiter
    import dmac_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    dmac_wr_arbiter_if.master    bus,
    output logic                 err_o
`ifdef DMAC_WR_ARB_GNT_CNT_EN
    , output logic [N_CH*16-1:0] gnt_cnt_o
`endif
);

    localparam int GNT_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int STRB_W = DATA_W / 8;

    dmac_state_t      r_state;
    logic [GNT_W-1:0] r_gnt;
    logic [GNT_W-1:0] r_rr_ptr;
    logic [3:0]       r_len_q;
    logic [3:0]       r_beat_cnt;
    logic             r_err;

    logic [GNT_W-1:0] w_arb_gnt;
    logic             w_arb_valid;
    logic             w_in_aw;
    logic             w_in_w;
    logic             w_awvalid;
    logic             w_wvalid;
    logic             w_aw_hs;
    logic             w_w_hs;
    logic             w_last;

    dmac_rr_arbiter #(
        .N_CH  (N_CH),
        .GNT_W (GNT_W)
    ) u_rr (
        .i_req   (bus.ch_awvalid_i),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_arb_gnt),
        .o_valid (w_arb_valid)
    );

    assign w_in_aw   = (r_state == AW);
    assign w_in_w    = (r_state == W);
    assign w_awvalid = w_in_aw & bus.ch_awvalid_i[r_gnt];
    assign w_wvalid  = w_in_w & bus.ch_wvalid_i[r_gnt];
    assign w_aw_hs   = w_awvalid & bus.awready_i;
    assign w_w_hs    = w_wvalid & bus.wready_i;
    // Burst end comes from the latched length, never from the engine's wlast.
    assign w_last    = (r_beat_cnt == r_len_q);

    assign bus.awvalid_o = w_awvalid;
    assign bus.awid_o    = ID_W'(r_gnt);
    assign bus.awaddr_o  = bus.ch_awaddr_i[r_gnt*ADDR_W +: ADDR_W];
    assign bus.awlen_o   = bus.ch_awlen_i[r_gnt*4 +: 4];
    assign bus.awsize_o  = AXI_SIZE_4B;
    assign bus.awburst_o = AXI_BURST_INCR;

    assign bus.wvalid_o  = w_wvalid;
    assign bus.wid_o     = ID_W'(r_gnt);
    assign bus.wdata_o   = bus.ch_wdata_i[r_gnt*DATA_W +: DATA_W];
    assign bus.wstrb_o   = bus.ch_wstrb_i[r_gnt*STRB_W +: STRB_W];
    assign bus.wlast_o   = w_in_w & w_last;

    assign bus.ch_bresp_o = bus.bresp_i;
    assign err_o          = r_err;

    // Ready fan-out to the owning channel and B routing by ID; unknown IDs are sunk.
    always_comb begin
        bus.ch_awready_o = '0;
        bus.ch_wready_o  = '0;
        bus.ch_bvalid_o  = '0;
        bus.bready_o     = 1'b1;
        if (w_in_aw) bus.ch_awready_o[r_gnt] = bus.awready_i;
        if (w_in_w)  bus.ch_wready_o[r_gnt]  = bus.wready_i;
        for (int k = 0; k < N_CH; k++) begin
            if (bus.bid_i == ID_W'(k)) begin
                bus.ch_bvalid_o[k] = bus.bvalid_i;
                bus.bready_o       = bus.ch_bready_i[k];
            end
        end
    end

    // Grant FSM: arbitrate in IDLE, hold the grant through AW and the whole W burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_rr_ptr   <= GNT_W'(N_CH - 1);
            r_len_q    <= '0;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_arb_valid) begin
                        r_gnt   <= w_arb_gnt;
                        r_len_q <= bus.ch_awlen_i[w_arb_gnt*4 +: 4];
                        r_state <= AW;
                    end
                end
                AW: begin
                    if (w_aw_hs) begin
                        r_rr_ptr   <= r_gnt;
                        r_beat_cnt <= '0;
                        r_state    <= W;
                    end
                end
                W: begin
                    if (w_w_hs) begin
                        r_beat_cnt <= r_beat_cnt + 4'd1;
                        if (bus.ch_wlast_i[r_gnt] != w_last) r_err <= 1'b1;
                        if (w_last) r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef DMAC_WR_ARB_GNT_CNT_EN
    logic [15:0] r_gnt_cnt [N_CH];

    // Saturating per-channel count of accepted AW handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) r_gnt_cnt[k] <= '0;
        end else if (w_aw_hs && (r_gnt_cnt[r_gnt] != 16'hFFFF)) begin
            r_gnt_cnt[r_gnt] <= r_gnt_cnt[r_gnt] + 16'd1;
        end
    end

    // Flatten counters so channel k sits at bits [k*16 +: 16].
    always_comb begin
        gnt_cnt_o = '0;
        for (int k = 0; k < N_CH; k++) gnt_cnt_o[k*16 +: 16] = r_gnt_cnt[k];
    end
`endif

endmodule
